// File: rtl/dma_ci_bidir_if.sv
// CI port and bus-master signal bundle of the bidirectional CI DMA.
// master = the DMA block, slave = the CPU plus arbiter/bus side.
interface dma_ci_bidir_if;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;
  logic        requestTransaction;
  logic        transactionGranted;
  logic [31:0] addressDataIn;
  logic        endTransactionIn;
  logic        dataValidIn;
  logic        busyIn;
  logic        busErrorIn;
  logic [31:0] addressDataOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic        readNotWriteOut;
  logic        beginTransactionOut;
  logic        endTransactionOut;
  logic        dataValidOut;

  modport master (
    input  start, ciN, valueA, valueB,
    input  transactionGranted,
    input  addressDataIn, endTransactionIn,
    input  dataValidIn, busyIn, busErrorIn,
    output done, result,
    output requestTransaction,
    output addressDataOut, byteEnablesOut,
    output burstSizeOut, readNotWriteOut,
    output beginTransactionOut,
    output endTransactionOut, dataValidOut
  );

  modport slave (
    output start, ciN, valueA, valueB,
    output transactionGranted,
    output addressDataIn, endTransactionIn,
    output dataValidIn, busyIn, busErrorIn,
    input  done, result,
    input  requestTransaction,
    input  addressDataOut, byteEnablesOut,
    input  burstSizeOut, readNotWriteOut,
    input  beginTransactionOut,
    input  endTransactionOut, dataValidOut
  );
endinterface

// File: rtl/dma_ci_bidir.sv
// Custom-instruction DMA with a local word buffer, moving
// bursts between the buffer and the system bus both ways.
module dma_ci_bidir #(
  parameter logic [7:0] customId  = 8'h00,
  parameter int         MEM_AW    = 9,
  parameter int         MAX_BURST = 16
) (
  input logic            clock,
  input logic            reset,
  dma_ci_bidir_if.master io
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int RW    = MEM_AW + 1;
  localparam logic [7:0] BMAX = 8'(MAX_BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_BEGIN, S_RD_BEAT,
    S_WR_BEAT, S_WR_END, S_ERR_DRAIN, S_NEXT
  } state_t;

  state_t state, state_n;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       mem_q;
  logic [31:0]       bus_addr, cur_bus;
  logic [MEM_AW-1:0] mem_addr, cur_mem;
  logic [RW-1:0]     block_size, remaining;
  logic [7:0]        burst;
  logic [8:0]        beats, cnt, plen;
  logic              wmode, done_flag, error;
  logic              wr_ack, rd_p, rd_ack;
  logic [2:0]        rd_sel;
  logic [31:0]       rd_res, rd_val, status;

  logic              hit, ci_wr, busy;
  logic              ctl_wr, go, berr;
  logic [2:0]        sel;
  logic [MEM_AW-1:0] ci_addr;
  logic              unused_bits;

  assign hit     = io.start && io.ciN == customId;
  assign sel     = io.valueA[MEM_AW+3:MEM_AW+1];
  assign ci_wr   = io.valueA[MEM_AW];
  assign ci_addr = io.valueA[MEM_AW-1:0];
  assign busy    = state != S_IDLE;
  assign status  = {29'd0, done_flag, error, busy};
  assign berr    = io.busErrorIn;

  assign unused_bits = ^io.valueA[31:MEM_AW+4];

  // both start bits at once, or any start while busy, is dropped
  assign ctl_wr = hit && ci_wr && sel == 3'd5 && !busy
               && !(io.valueB[0] && io.valueB[1]);
  assign go = ctl_wr && (io.valueB[0] || io.valueB[1])
           && block_size != '0;

  assign plen =
    (16'(burst) + 16'd1 < 16'(remaining))
      ? 9'(burst) + 9'd1 : 9'(remaining);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n                = state;
    io.requestTransaction  = 1'b0;
    io.beginTransactionOut = 1'b0;
    io.endTransactionOut   = 1'b0;
    io.dataValidOut        = 1'b0;
    io.readNotWriteOut     = 1'b0;
    io.addressDataOut      = '0;
    io.byteEnablesOut      = '0;
    io.burstSizeOut        = '0;
    unique case (state)
      S_IDLE: if (go) state_n = S_REQ;
      S_REQ: begin
        io.requestTransaction = 1'b1;
        if (io.transactionGranted) state_n = S_BEGIN;
      end
      S_BEGIN: begin
        io.requestTransaction  = 1'b1;
        io.beginTransactionOut = 1'b1;
        io.addressDataOut      = cur_bus;
        io.byteEnablesOut      = 4'hF;
        io.burstSizeOut        = 8'(plen - 9'd1);
        io.readNotWriteOut     = !wmode;
        if (berr)
          state_n = io.endTransactionIn ? S_IDLE : S_ERR_DRAIN;
        else
          state_n = wmode ? S_WR_BEAT : S_RD_BEAT;
      end
      S_RD_BEAT: begin
        io.requestTransaction = 1'b1;
        if (berr)
          state_n = io.endTransactionIn ? S_IDLE : S_ERR_DRAIN;
        else if (io.endTransactionIn)
          state_n = S_NEXT;
      end
      S_WR_BEAT: begin
        io.requestTransaction = 1'b1;
        io.dataValidOut       = 1'b1;
        io.addressDataOut     = mem[cur_mem];
        io.byteEnablesOut     = 4'hF;
        if (berr)
          state_n = io.endTransactionIn ? S_IDLE : S_ERR_DRAIN;
        else if (!io.busyIn && cnt + 9'd1 == beats)
          state_n = S_WR_END;
      end
      S_WR_END: begin
        io.requestTransaction = 1'b1;
        io.endTransactionOut  = 1'b1;
        state_n = S_NEXT;
      end
      S_ERR_DRAIN: begin
        io.requestTransaction = 1'b1;
        if (io.endTransactionIn) state_n = S_IDLE;
      end
      S_NEXT: state_n = remaining == '0 ? S_IDLE : S_REQ;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_addr   <= '0;
      mem_addr   <= '0;
      block_size <= '0;
      burst      <= '0;
      cur_bus    <= '0;
      cur_mem    <= '0;
      remaining  <= '0;
      beats      <= '0;
      cnt        <= '0;
      wmode      <= 1'b0;
      done_flag  <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (hit && ci_wr && !busy) begin
        unique case (sel)
          3'd1: bus_addr <= {io.valueB[31:2], 2'b00};
          3'd2: mem_addr <= io.valueB[MEM_AW-1:0];
          3'd3: block_size <= io.valueB[MEM_AW:0];
          3'd4: burst <= (io.valueB > 32'(BMAX))
                         ? BMAX : io.valueB[7:0];
          default: ;
        endcase
      end
      if (ctl_wr) begin
        error     <= 1'b0;
        done_flag <= (io.valueB[0] || io.valueB[1])
                  && block_size == '0;
      end
      if (go) begin
        cur_bus   <= bus_addr;
        cur_mem   <= mem_addr;
        remaining <= block_size;
        wmode     <= io.valueB[1];
      end
      if (state == S_BEGIN) begin
        beats <= plen;
        cnt   <= '0;
      end
      if ((state == S_BEGIN || state == S_RD_BEAT
           || state == S_WR_BEAT) && berr)
        error <= 1'b1;
      if (!berr && ((state == S_RD_BEAT && io.dataValidIn)
          || (state == S_WR_BEAT && !io.busyIn))) begin
        cur_mem   <= cur_mem + 1'b1;
        remaining <= remaining - 1'b1;
        cnt       <= cnt + 9'd1;
      end
      if (state == S_NEXT) begin
        cur_bus <= cur_bus + {21'd0, cnt, 2'b00};
        if (remaining == '0) done_flag <= 1'b1;
      end
    end
  end

  // CI write is last so it overrides a DMA write to the same word
  always_ff @(posedge clock) begin
    if (state == S_RD_BEAT && io.dataValidIn && !berr)
      mem[cur_mem] <= io.addressDataIn;
    if (hit && ci_wr && sel == 3'd0)
      mem[ci_addr] <= io.valueB;
    if (hit && !ci_wr)
      mem_q <= mem[ci_addr];
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      rd_sel == 3'd0: rd_val = mem_q;
      rd_sel == 3'd5: rd_val = status;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ack <= 1'b0;
      rd_p   <= 1'b0;
      rd_ack <= 1'b0;
      rd_sel <= '0;
      rd_res <= '0;
    end else begin
      wr_ack <= hit && ci_wr;
      rd_p   <= hit && !ci_wr;
      rd_sel <= sel;
      rd_ack <= rd_p;
      rd_res <= rd_p ? rd_val : '0;
    end
  end

  assign io.done   = wr_ack | rd_ack;
  assign io.result = rd_res;

endmodule

// File: tb/tb_dma_ci_bidir.sv
// Randomised bench for dma_ci_bidir: the bench plays CPU and bus
// slave and checks every bus cycle against a transfer-level model.
module tb_dma_ci_bidir;
  localparam int AW = 9;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dma_ci_bidir_if ifc();

  dma_ci_bidir #(
    .customId(8'h00), .MEM_AW(AW), .MAX_BURST(16)
  ) dut (
    .clock(clock), .reset(reset), .io(ifc.master)
  );

  logic [31:0] mem_m [DEPTH];
  logic [31:0] bus_addr_m;
  int mem_addr_m, bsize_m, burst_m;
  bit busy_m;
  logic [31:0] beg_q[$];
  int bsz_q[$];
  int hold_cnt, ends_cnt;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return a < b ? a : b;
  endfunction

  task automatic clear_bus();
    ifc.transactionGranted = 0;
    ifc.dataValidIn = 0;
    ifc.endTransactionIn = 0;
    ifc.busErrorIn = 0;
    ifc.busyIn = 0;
  endtask

  task automatic ci_write(input int sel, input int addr,
                          input logic [31:0] d);
    int unsigned du;
    ifc.start = 1; ifc.ciN = 8'h00;
    ifc.valueA = (32'(sel) << (AW + 1)) | (32'd1 << AW)
               | 32'(addr % DEPTH);
    ifc.valueB = d;
    tick();
    ifc.start = 0;
    chk("ci_wr_done", 32'(ifc.done), 1);
    chk("ci_wr_result", ifc.result, 0);
    du = d;
    if (sel == 0) mem_m[addr % DEPTH] = d;
    if (!busy_m) begin
      case (sel)
        1: bus_addr_m = d & 32'hFFFF_FFFC;
        2: mem_addr_m = int'(du % DEPTH);
        3: bsize_m = int'(du % (2 * DEPTH));
        4: burst_m = du > 15 ? 15 : int'(du);
        default: ;
      endcase
    end
  endtask

  task automatic ci_read(input int sel, input int addr,
                         input logic [31:0] e, input string n);
    ifc.start = 1; ifc.ciN = 8'h00;
    ifc.valueA = (32'(sel) << (AW + 1)) | 32'(addr % DEPTH);
    tick();
    ifc.start = 0;
    chk({n, "_early"}, 32'(ifc.done), 0);
    tick();
    chk({n, "_done"}, 32'(ifc.done), 1);
    chk(n, ifc.result, e);
  endtask

  task automatic run_xfer(input bit wm, input bit do_start,
                          input int err_beat, input int busy_beat,
                          input int busy_len, input bit rnd_busy);
    int off = 0, nb = 0, bi = 0, phase = 0, cyc = 0;
    int busy_left = 0;
    bit busy_used = 0, erred = 0;
    logic [31:0] d;
    beg_q.delete(); bsz_q.delete();
    hold_cnt = 0; ends_cnt = 0;
    if (do_start) ci_write(5, 0, wm ? 32'd2 : 32'd1);
    busy_m = 1;
    while (phase != 4 && cyc < 3000) begin
      clear_bus();
      if (phase != 2) chk("dv_out_idle", 32'(ifc.dataValidOut), 0);
      if (phase != 6) chk("end_out_idle", 32'(ifc.endTransactionOut), 0);
      if (phase != 0) chk("begin_unexp", 32'(ifc.beginTransactionOut), 0);
      case (phase)
        0: if (ifc.beginTransactionOut) begin
             nb = imin(burst_m + 1, bsize_m - off);
             beg_q.push_back(ifc.addressDataOut);
             bsz_q.push_back(int'(ifc.burstSizeOut));
             chk("begin_addr", ifc.addressDataOut,
                 bus_addr_m + 32'(4 * off));
             chk("burst_size", 32'(ifc.burstSizeOut), 32'(nb - 1));
             chk("rnw", 32'(ifc.readNotWriteOut), 32'(!wm));
             chk("be_begin", 32'(ifc.byteEnablesOut), 32'hF);
             chk("req_begin", 32'(ifc.requestTransaction), 1);
             bi = 0;
             phase = wm ? 2 : 1;
           end else if (ifc.requestTransaction) begin
             ifc.transactionGranted = 1'($urandom_range(0, 1));
           end
        1: if ($urandom_range(0, 3) != 0) begin
             if (off == err_beat) begin
               ifc.busErrorIn = 1;
               erred = 1;
               phase = 3;
             end else begin
               d = $urandom;
               ifc.addressDataIn = d;
               ifc.dataValidIn = 1;
               mem_m[(mem_addr_m + off) % DEPTH] = d;
               off++; bi++;
               if (bi == nb) begin
                 ifc.endTransactionIn = 1;
                 phase = off == bsize_m ? 4 : 0;
               end
             end
           end
        2: begin
             chk("dv_out", 32'(ifc.dataValidOut), 1);
             chk("be_data", 32'(ifc.byteEnablesOut), 32'hF);
             chk("wr_data", ifc.addressDataOut,
                 mem_m[(mem_addr_m + off) % DEPTH]);
             if (off == 2) hold_cnt++;
             if (off == busy_beat && !busy_used) begin
               busy_used = 1;
               busy_left = busy_len;
             end
             if (busy_left > 0) begin
               ifc.busyIn = 1;
               busy_left--;
             end else if (rnd_busy && $urandom_range(0, 3) == 0) begin
               ifc.busyIn = 1;
             end else begin
               off++; bi++;
               if (bi == nb) phase = 6;
             end
           end
        3: begin
             ifc.endTransactionIn = 1;
             phase = 4;
           end
        6: begin
             chk("wr_end", 32'(ifc.endTransactionOut), 1);
             if (ifc.endTransactionOut) ends_cnt++;
             phase = off == bsize_m ? 4 : 0;
           end
        default: phase = 4;
      endcase
      tick();
      cyc++;
    end
    chk("xfer_timeout", 32'(phase), 4);
    clear_bus();
    tick(); tick();
    busy_m = 0;
    chk("req_after", 32'(ifc.requestTransaction), 0);
    ci_read(5, 0, erred ? 32'd2 : 32'd4, "status");
  endtask

  initial begin
    logic [31:0] rv;
    bit wm;
    ifc.start = 0; ifc.ciN = 0; ifc.valueA = 0; ifc.valueB = 0;
    ifc.addressDataIn = 0;
    clear_bus();
    busy_m = 0; bus_addr_m = 0;
    mem_addr_m = 0; bsize_m = 0; burst_m = 0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_done", 32'(ifc.done), 0);
    chk("rst_result", ifc.result, 0);
    chk("rst_req", 32'(ifc.requestTransaction), 0);
    chk("rst_begin", 32'(ifc.beginTransactionOut), 0);
    chk("rst_addr", ifc.addressDataOut, 0);
    chk("rst_be", 32'(ifc.byteEnablesOut), 0);
    reset = 1;
    tick();
    ci_read(5, 0, 32'd0, "rst_status");

    ci_write(0, 5, 32'hDEADBEEF);
    ci_read(0, 5, 32'hDEADBEEF, "buf5");

    ifc.start = 1; ifc.ciN = 8'h01; ifc.valueA = 0;
    tick();
    ifc.start = 0;
    tick();
    chk("wrong_ciN", 32'(ifc.done), 0);

    for (int i = 0; i < DEPTH; i++) ci_write(0, i, $urandom);

    // read mode, 10 words in bursts of 4
    ci_write(1, 0, 32'h100); ci_write(2, 0, 0);
    ci_write(3, 0, 10);      ci_write(4, 0, 3);
    run_xfer(0, 1, -1, -1, 0, 0);
    chk("t2_nbursts", 32'(beg_q.size()), 3);
    if (beg_q.size() == 3) begin
      chk("t2_beg0", beg_q[0], 32'h100);
      chk("t2_beg1", beg_q[1], 32'h110);
      chk("t2_beg2", beg_q[2], 32'h120);
      chk("t2_bsz0", 32'(bsz_q[0]), 3);
      chk("t2_bsz2", 32'(bsz_q[2]), 1);
    end
    for (int i = 0; i < 10; i++) ci_read(0, i, mem_m[i], "t2_buf");

    // write mode with a stall on beat 2
    ci_write(3, 0, 4); ci_write(4, 0, 7);
    run_xfer(1, 1, -1, 2, 3, 0);
    chk("t3_bsz", 32'(bsz_q[0]), 3);
    chk("t3_hold", 32'(hold_cnt), 4);
    chk("t3_ends", 32'(ends_cnt), 1);

    // bus error on beat 2, drained a cycle later
    ci_write(3, 0, 8);
    run_xfer(0, 1, 2, -1, 0, 0);
    ci_write(5, 0, 0);
    ci_read(5, 0, 32'd0, "err_cleared");

    // buffer address wrap
    ci_write(2, 0, DEPTH - 2); ci_write(3, 0, 4);
    run_xfer(0, 1, -1, -1, 0, 0);
    ci_read(0, DEPTH - 2, mem_m[DEPTH - 2], "wrap510");
    ci_read(0, DEPTH - 1, mem_m[DEPTH - 1], "wrap511");
    ci_read(0, 0, mem_m[0], "wrap0");
    ci_read(0, 1, mem_m[1], "wrap1");

    // bus address wrap and burst clamp
    ci_write(1, 0, 32'hFFFF_FFFB); ci_write(4, 0, 1);
    run_xfer(0, 1, -1, -1, 0, 0);
    chk("bus_wrap", beg_q.size() > 1 ? beg_q[1] : 32'hX, 32'h0);
    ci_write(4, 0, 200); ci_write(3, 0, 20);
    run_xfer(1, 1, -1, -1, 0, 1);
    chk("clamp", 32'(bsz_q[0]), 15);

    // empty block completes at once
    ci_write(3, 0, 0); ci_write(5, 0, 1);
    chk("empty_req", 32'(ifc.requestTransaction), 0);
    ci_read(5, 0, 32'd4, "empty_status");

    // writes while busy are ignored
    ci_write(1, 0, 32'h200); ci_write(2, 0, 20);
    ci_write(3, 0, 3);       ci_write(4, 0, 0);
    ci_write(5, 0, 1);
    busy_m = 1;
    ci_write(1, 0, 32'h900); ci_write(4, 0, 5);
    ci_write(5, 0, 2);
    ci_read(5, 0, 32'd1, "busy_status");
    run_xfer(0, 0, -1, -1, 0, 1);
    chk("busy_beg2", beg_q.size() > 2 ? beg_q[2] : 32'hX, 32'h208);

    for (int t = 0; t < 6; t++) begin
      wm = 1'($urandom_range(0, 1));
      rv = $urandom;
      ci_write(1, 0, rv);
      ci_write(2, 0, $urandom_range(0, DEPTH - 1));
      ci_write(3, 0, $urandom_range(1, 20));
      ci_write(4, 0, $urandom_range(0, 40));
      run_xfer(wm, 1, -1, -1, 0, 1);
      ci_read(0, mem_addr_m, mem_m[mem_addr_m], "rnd_buf");
    end

    // reset in the middle of a write burst
    ci_write(1, 0, 32'h40); ci_write(2, 0, 0);
    ci_write(3, 0, 4);      ci_write(4, 0, 3);
    ci_write(5, 0, 2);
    busy_m = 1;
    for (int i = 0; i < 50 && !ifc.beginTransactionOut; i++) begin
      ifc.transactionGranted = ifc.requestTransaction;
      tick();
    end
    ifc.transactionGranted = 0;
    chk("mid_begin", 32'(ifc.beginTransactionOut), 1);
    tick();
    chk("mid_dv", 32'(ifc.dataValidOut), 1);
    #2 reset = 0;
    #1;
    chk("mid_req", 32'(ifc.requestTransaction), 0);
    chk("mid_dv0", 32'(ifc.dataValidOut), 0);
    chk("mid_addr", ifc.addressDataOut, 0);
    chk("mid_be", 32'(ifc.byteEnablesOut), 0);
    chk("mid_end", 32'(ifc.endTransactionOut), 0);
    @(posedge clock);
    #3 reset = 1;
    tick();
    busy_m = 0;
    bus_addr_m = 0; mem_addr_m = 0; bsize_m = 0; burst_m = 0;
    chk("post_req", 32'(ifc.requestTransaction), 0);
    ci_read(5, 0, 32'd0, "post_rst_status");
    ci_write(5, 0, 1);
    ci_read(5, 0, 32'd4, "post_rst_bsize0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
